// File: rtl/bit_pkg.sv
// Shared constants and alignment helper for the bit packer / unpacker pair.
package bit_pkg;

    localparam int WORD_W = 64;          // packed word width, fixed
    localparam int WIN_W  = 32;          // decoder peek window
    localparam int ADV_W  = 5;           // advance field, 0..31 bits
    localparam int BUF_W  = 2 * WORD_W;  // staging buffer, two words deep
    localparam int LVL_W  = 8;           // buffer fill level, 0..128
    localparam int POS_W  = 7;           // bit position inside a word, 0..63
    localparam int SKIP_W = 4;           // align skip, 1..8

    // Bits to reach the next byte boundary; an aligned position skips a full byte
    // so the packer and unpacker agree on where padding lives.
    function automatic logic [SKIP_W-1:0] align_skip_f(input logic [2:0] pos);
        return 4'd8 - {1'b0, pos};
    endfunction

endpackage

// File: rtl/bit_align_tracker.sv
// Tracks the consumed bit position within the current 64-bit word and
// produces the byte-align skip amount plus a word-boundary pulse.
module bit_align_tracker
    import bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              adv_i,
    input  logic [ADV_W-1:0]  amt_i,
    output logic [SKIP_W-1:0] align_skip_o,
    output logic [POS_W-1:0]  word_pos_o,
    output logic              word_done_o
);

    logic [POS_W-1:0] word_pos_q, word_pos_d;
    logic             word_done_q, word_done_d;
    logic [POS_W-1:0] sum;

    // pos mod 8 is the low three bits of word_pos, since 64 is a multiple of 8
    assign align_skip_o = align_skip_f(word_pos_q[2:0]);
    assign word_pos_o   = word_pos_q;
    assign word_done_o  = word_done_q;

    // Advance position; crossing 64 wraps and flags a finished word
    always_comb begin
        sum         = word_pos_q + POS_W'(amt_i);
        word_pos_d  = word_pos_q;
        word_done_d = 1'b0;
        if (adv_i) begin
            if (sum >= POS_W'(WORD_W)) begin
                word_pos_d  = sum - POS_W'(WORD_W);
                word_done_d = 1'b1;
            end else begin
                word_pos_d  = sum;
            end
        end
    end

    // Position and pulse registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_pos_q  <= '0;
            word_done_q <= 1'b0;
        end else begin
            word_pos_q  <= word_pos_d;
            word_done_q <= word_done_d;
        end
    end

endmodule

// File: rtl/bit_unpacker.sv
// Receive-side bit unpacker: buffers packed 64-bit words and presents a
// 32-bit MSB-first peek window to the symbol decoder.
module bit_unpacker
    import bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIN_W-1:0]  win_data,
    output logic              win_valid,
    input  logic              adv_en,
    input  logic [ADV_W-1:0]  advance,
    input  logic              align,
    output logic [POS_W-1:0]  word_pos,
    output logic              word_done,
    output logic              underflow
);

    logic [BUF_W-1:0]  sbuf_q, sbuf_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              win_valid_q, win_valid_d;
    logic              underflow_q, underflow_d;
    logic [BUF_W-1:0]  fill;
    logic [LVL_W-1:0]  wr_off;
    logic [SKIP_W-1:0] align_skip;
    logic [ADV_W-1:0]  amt;
    logic              consume;
    logic              accept;

    // Ready depends only on level and reset so the FIFO side never loops back
    assign in_ready  = rst && (level_q <= LVL_W'(WORD_W));
    assign accept    = in_valid && in_ready;
    assign consume   = adv_en && win_valid_q;

    assign win_data  = sbuf_q[BUF_W-1 -: WIN_W];
    assign win_valid = win_valid_q;
    assign underflow = underflow_q;

    // Amount consumed this cycle; zero when not consuming keeps the shifter idle
    always_comb begin
        amt = '0;
        if (consume) begin
            amt = align ? ADV_W'(align_skip) : advance;
        end
    end

    bit_align_tracker u_trk (
        .clk          (clk),
        .rst          (rst),
        .adv_i        (consume),
        .amt_i        (amt),
        .align_skip_o (align_skip),
        .word_pos_o   (word_pos),
        .word_done_o  (word_done)
    );

    // Shift out consumed bits and drop an accepted word right behind the survivors
    always_comb begin
        wr_off      = level_q - LVL_W'(amt);
        fill        = '0;
        sbuf_d      = sbuf_q << amt;
        level_d     = wr_off;
        if (accept) begin
            fill    = {in_data, {WORD_W{1'b0}}} >> wr_off;
            sbuf_d  = sbuf_d | fill;
            level_d = wr_off + LVL_W'(WORD_W);
        end
        win_valid_d = (level_d >= LVL_W'(WIN_W));
        underflow_d = underflow_q | (adv_en & ~win_valid_q);
    end

    // Buffer, level and status registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            sbuf_q      <= '0;
            level_q     <= '0;
            win_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sbuf_q      <= sbuf_d;
            level_q     <= level_d;
            win_valid_q <= win_valid_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
